// File: rtl/six502_pkg.sv
// Shared 6502-family constants: reset-sequencer state encoding, stack page and
// hardware vector addresses used by the CPU-side blocks.
package six502_pkg;

  localparam logic [3:0] RS_HOLD   = 4'd0;
  localparam logic [3:0] RS_DUMMY0 = 4'd1;
  localparam logic [3:0] RS_DUMMY1 = 4'd2;
  localparam logic [3:0] RS_STK0   = 4'd3;
  localparam logic [3:0] RS_STK1   = 4'd4;
  localparam logic [3:0] RS_STK2   = 4'd5;
  localparam logic [3:0] RS_VEC_LO = 4'd6;
  localparam logic [3:0] RS_VEC_HI = 4'd7;
  localparam logic [3:0] RS_RUN    = 4'd8;

  localparam logic [7:0]  STACK_PAGE   = 8'h01;
  localparam logic [15:0] NMI_VECTOR   = 16'hFFFA;
  localparam logic [15:0] RESET_VECTOR = 16'hFFFC;
  localparam logic [15:0] IRQ_VECTOR   = 16'hFFFE;

endpackage

// File: rtl/reset_seq.sv
// 6502 reset bus sequence: two dummy PC reads, three dummy stack reads with SP
// decrement, then the two-byte reset-vector fetch before releasing the core.
module reset_seq
  import six502_pkg::*;
#(
  parameter logic [15:0] VECTOR_ADDR = RESET_VECTOR,
  parameter logic [7:0]  SP_INIT     = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] pc,
  output logic [7:0]  sp,
  output logic        flag_i,
  output logic        cpu_run
);

  // 16-bit addition so a vector at 16'hFFFF wraps its high byte to 16'h0000
  localparam logic [15:0] VEC_HI_ADDR = VECTOR_ADDR + 16'd1;

  logic [3:0]  r_state;
  logic [15:0] r_memAddr;
  logic        r_memRd;
  logic [15:0] r_pc;
  logic [7:0]  r_sp;
  logic        r_flagI;
  logic        r_cpuRun;

  logic        w_transfer;
  logic [7:0]  w_spDec;

  assign w_transfer = clk_enable & mem_ready;
  assign w_spDec    = r_sp - 8'd1;

  // The address of each bus state is loaded on the edge that enters it, so
  // every output comes straight from a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= RS_HOLD;
      r_memAddr <= 16'h0000;
      r_memRd   <= 1'b0;
      r_pc      <= 16'h0000;
      r_sp      <= SP_INIT;
      r_flagI   <= 1'b1;
      r_cpuRun  <= 1'b0;
    end else if (clk_enable) begin
      case (r_state)
        RS_HOLD: begin
          r_state   <= RS_DUMMY0;
          r_memAddr <= r_pc;
          r_memRd   <= 1'b1;
        end
        RS_DUMMY0: if (w_transfer) begin
          r_state   <= RS_DUMMY1;
          r_memAddr <= r_pc + 16'd1;
        end
        RS_DUMMY1: if (w_transfer) begin
          r_state   <= RS_STK0;
          r_memAddr <= {STACK_PAGE, r_sp};
        end
        RS_STK0, RS_STK1: if (w_transfer) begin
          r_state   <= (r_state == RS_STK0) ? RS_STK1 : RS_STK2;
          r_sp      <= w_spDec;
          r_memAddr <= {STACK_PAGE, w_spDec};
        end
        RS_STK2: if (w_transfer) begin
          r_state   <= RS_VEC_LO;
          r_sp      <= w_spDec;
          r_memAddr <= VECTOR_ADDR;
        end
        RS_VEC_LO: if (w_transfer) begin
          r_state    <= RS_VEC_HI;
          r_pc[7:0]  <= mem_rdata;
          r_memAddr  <= VEC_HI_ADDR;
        end
        RS_VEC_HI: if (w_transfer) begin
          r_state    <= RS_RUN;
          r_pc[15:8] <= mem_rdata;
          r_memAddr  <= {mem_rdata, r_pc[7:0]};
          r_memRd    <= 1'b0;
          r_cpuRun   <= 1'b1;
        end
        RS_RUN: begin
        end
        default: begin
          r_state <= RS_HOLD;
          r_memRd <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr = r_memAddr;
  assign mem_rd   = r_memRd;
  assign pc       = r_pc;
  assign sp       = r_sp;
  assign flag_i   = r_flagI;
  assign cpu_run  = r_cpuRun;

endmodule
